// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings and oversampling/stop-bit presets.
// Used by uart_tx, uart_rx and baud_rate_gen.
package uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } uart_state_e;

  localparam int OVERSAMPLE_DEF = 16;

  localparam int SB_TICK_1   = 16;
  localparam int SB_TICK_1P5 = 24;
  localparam int SB_TICK_2   = 32;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter paced by an external 16x oversampling tick.
// Accepts a byte on i_tx_start and pulses o_tx_done as the stop bit ends.
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int SB_TICK    = SB_TICK_1,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy
);

  localparam int CNT_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = $clog2(NB_DATA);

  localparam logic [CW-1:0] CNT_OS   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_SB   = CW'(SB_TICK - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NB_DATA - 1);

  uart_state_e        state_q;
  logic [CW-1:0]      cnt_q;
  logic [IW-1:0]      idx_q;
  logic [NB_DATA-1:0] shift_q;
  logic [NB_DATA-1:0] shift_d;
  logic               tx_q;
  logic               done_q;

  assign shift_d = shift_q >> 1;

  // tx_q is loaded with the level of the state being entered,
  // so the line moves in the same cycle as the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_tx_start) begin
            shift_q <= i_data;
            cnt_q   <= '0;
            state_q <= ST_START;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (i_tick) begin
            if (cnt_q == CNT_OS) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= ST_DATA;
              tx_q    <= shift_q[0];
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_DATA: begin
          if (i_tick) begin
            if (cnt_q == CNT_OS) begin
              cnt_q   <= '0;
              shift_q <= shift_d;
              if (idx_q == IDX_LAST) begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end else begin
                idx_q <= idx_q + IW'(1);
                tx_q  <= shift_d[0];
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_STOP: begin
          if (i_tick) begin
            if (cnt_q == CNT_SB) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_done = done_q;
  assign o_busy    = (state_q != ST_IDLE);

endmodule
